shift_seq: RTL and testbench

Multi-cycle sequencer for the 16-bit barrel shift datapath. It accepts one shift request, applies the 1/2/4/8-bit stages one per clock from a single internal shift stage, and returns the registered result with a one-cycle `done` pulse. It sits between the execute-stage control and the ALU result mux, and lets the single-cycle shifter leave the critical path when timing requires it.

---
 rtl/shift_seq_if.sv | 21 ++
 rtl/shift_seq.sv | 150 +++++++++++++++
 tb/tb_shift_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_if.sv
// Request/response bundle for shift_seq: operand capture signals plus busy/done/out.
// The master drives a request; the slave (shift_seq) returns status and result.
interface shift_seq_if;
    logic        start;
    logic [15:0] in;
    logic [3:0]  cnt;
    logic [2:0]  op;
    logic        busy;
    logic        done;
    logic [15:0] out;

    modport master (
        output start, in, cnt, op,
        input  busy, done, out
    );

    modport slave (
        input  start, in, cnt, op,
        output busy, done, out
    );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle 16-bit shift sequencer: applies the 1/2/4/8 stages one per clock.
// Optional macro SHIFT_SEQ_SKIP_EN visits only the stages selected by cnt.
module shift_seq (
    input  logic         clk,
    input  logic         rst,
    shift_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nx;
    logic [15:0] work_r;
    logic [15:0] work_nx;
    logic [15:0] out_r;
    logic [15:0] out_nx;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_nx;
    logic [2:0]  op_r;
    logic [2:0]  op_nx;
    logic [1:0]  k_r;
    logic [1:0]  k_nx;
    logic        busy_r;
    logic        done_r;
    logic [15:0] stage_s;
    logic [1:0]  first_k_s;
    logic [1:0]  next_k_s;
    logic        last_s;

    // One shift stage by 2^k; SRA fills from bit 15 of the current value.
    function automatic logic [15:0] shift_stage(
        input logic [15:0] w,
        input logic [2:0]  op,
        input logic [1:0]  k
    );
        logic [4:0]  amt;
        logic [15:0] r;
        amt = 5'd1 << k;
        case (op)
            3'b000:  r = (w << amt) | (w >> (5'd16 - amt));
            3'b001:  r = w << amt;
            3'b010:  r = (w >> amt) | (w << (5'd16 - amt));
            3'b011:  r = w >> amt;
            3'b100:  r = 16'($signed(w) >>> amt);
            default: r = w;
        endcase
        return r;
    endfunction

`ifdef SHIFT_SEQ_SKIP_EN
    logic [3:0] above_s;

    // Index of the lowest set bit; zero when none is set.
    function automatic logic [1:0] lowest_set(input logic [3:0] c);
        logic [1:0] idx;
        if (c[0]) begin
            idx = 2'd0;
        end else if (c[1]) begin
            idx = 2'd1;
        end else if (c[2]) begin
            idx = 2'd2;
        end else if (c[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

    // Stages still pending above k; (2<<3) wraps to zero so k=3 masks everything.
    assign above_s   = cnt_r & ~((4'd2 << k_r) - 4'd1);
    assign first_k_s = lowest_set(bus.cnt);
    assign next_k_s  = lowest_set(above_s);
    assign last_s    = (above_s == 4'd0);
`else
    assign first_k_s = 2'd0;
    assign next_k_s  = k_r + 2'd1;
    assign last_s    = (k_r == 2'd3);
`endif

    assign stage_s = cnt_r[k_r] ? shift_stage(work_r, op_r, k_r) : work_r;

    // Next-state and datapath update; a request is accepted in IDLE or DONE.
    always_comb begin
        state_nx = state_r;
        work_nx  = work_r;
        cnt_nx   = cnt_r;
        op_nx    = op_r;
        k_nx     = k_r;
        out_nx   = out_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    work_nx  = bus.in;
                    cnt_nx   = bus.cnt;
                    op_nx    = bus.op;
                    k_nx     = first_k_s;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                work_nx = stage_s;
                if (last_s) begin
                    out_nx   = stage_s;
                    state_nx = DONE;
                end else begin
                    k_nx     = next_k_s;
                    state_nx = RUN;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            work_r  <= 16'h0000;
            cnt_r   <= 4'd0;
            op_r    <= 3'd0;
            k_r     <= 2'd0;
            out_r   <= 16'h0000;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            work_r  <= work_nx;
            cnt_r   <= cnt_nx;
            op_r    <= op_nx;
            k_r     <= k_nx;
            out_r   <= out_nx;
            busy_r  <= (state_nx == RUN);
            done_r  <= (state_nx == DONE);
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.out  = out_r;

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq; honours SHIFT_SEQ_SKIP_EN for latency.
module tb_shift_seq;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    shift_seq_if bus ();

    shift_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SHIFT_SEQ_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [15:0] a;
        logic [3:0]  c;
        logic [2:0]  o;
        logic [15:0] exp;
        int          lat_def;
        int          lat_skip;
    } vec_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request and wait (bounded) for done.
    task automatic issue(input logic [15:0] a, input logic [3:0] c, input logic [2:0] o,
                         output int lat, output logic [15:0] res,
                         output logic busy0, output int overlap);
        bus.start = 1'b1;
        bus.in    = a;
        bus.cnt   = c;
        bus.op    = o;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in    = ~a;
        bus.cnt   = ~c;
        bus.op    = ~o;
        busy0   = bus.busy;
        overlap = 0;
        lat     = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) break;
        end
        res = bus.out;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.in = 16'h0000;
        bus.cnt = 4'd0;
        bus.op = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({bus.out, bus.busy, bus.done} !== {16'h0000, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: out=%h busy=%b done=%b, want 0000/0/0",
                         i, bus.out, bus.busy, bus.done);
            end
        end
    endtask

    task automatic check_req(input string name, input vec_t v);
        int          lat;
        int          ov;
        logic [15:0] res;
        logic        b0;
        int          want_lat;
        want_lat = SKIP ? v.lat_skip : v.lat_def;
        issue(v.a, v.c, v.o, lat, res, b0, ov);
        tests++;
        if (res !== v.exp) begin
            fails++;
            $display("FAIL %s out: got %h want %h", name, res, v.exp);
        end
        tests++;
        if (lat !== want_lat) begin
            fails++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
        end
        tests++;
        if (b0 !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, b0);
        end
        tests++;
        if (ov !== 0) begin
            fails++;
            $display("FAIL %s busy_done_overlap: got %0d want 0", name, ov);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.done !== 1'b0) begin
            fails++;
            $display("FAIL %s done_single_pulse: got %b want 0", name, bus.done);
        end
    endtask

    task automatic test_ops();
        vec_t tbl[8];
        tbl[0] = '{16'h00F1, 4'd4,  3'b001, 16'h0F10, 4, 1};
        tbl[1] = '{16'h8001, 4'd15, 3'b100, 16'hFFFF, 4, 4};
        tbl[2] = '{16'h0001, 4'd1,  3'b010, 16'h8000, 4, 1};
        tbl[3] = '{16'h1234, 4'd4,  3'b000, 16'h2341, 4, 1};
        tbl[4] = '{16'h8000, 4'd15, 3'b011, 16'h0001, 4, 4};
        tbl[5] = '{16'h4000, 4'd3,  3'b100, 16'h0800, 4, 2};
        tbl[6] = '{16'h1234, 4'd8,  3'b010, 16'h3412, 4, 1};
        tbl[7] = '{16'hFFFF, 4'd15, 3'b001, 16'h8000, 4, 4};
        for (int i = 0; i < 8; i++) begin
            check_req($sformatf("op_vec%0d", i), tbl[i]);
        end
    endtask

    task automatic test_passthru();
        vec_t v;
        v = '{16'hBEEF, 4'd5, 3'b110, 16'hBEEF, 4, 2};
        check_req("passthru", v);
        v = '{16'h1234, 4'd0, 3'b011, 16'h1234, 4, 1};
        check_req("zero_cnt", v);
    endtask

    task automatic test_back_to_back();
        int          lat;
        int          ov;
        logic [15:0] res;
        logic        b0;
        int          dones;
        issue(16'h00F1, 4'd4, 3'b001, lat, res, b0, ov);
        tests++;
        if (res !== 16'h0F10) begin
            fails++;
            $display("FAIL b2b_first out: got %h want 0F10", res);
        end
        // Still in the DONE cycle of the first request here.
        issue(16'h8001, 4'd1, 3'b000, lat, res, b0, ov);
        tests++;
        if (b0 !== 1'b1) begin
            fails++;
            $display("FAIL b2b_no_idle busy: got %b want 1", b0);
        end
        tests++;
        if (res !== 16'h0003) begin
            fails++;
            $display("FAIL b2b_second out: got %h want 0003", res);
        end
        tests++;
        if (lat !== (SKIP ? 1 : 4)) begin
            fails++;
            $display("FAIL b2b_second latency: got %0d want %0d", lat, SKIP ? 1 : 4);
        end
        @(posedge clk); #1;
        // Start held across the first RUN edge must be ignored.
        bus.start = 1'b1;
        bus.in    = 16'hF000;
        bus.cnt   = 4'd12;
        bus.op    = 3'b011;
        @(posedge clk); #1;
        bus.in    = 16'hAAAA;
        bus.cnt   = 4'd1;
        bus.op    = 3'b000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dones++;
            @(posedge clk); #1;
        end
        tests++;
        if (dones !== 1) begin
            fails++;
            $display("FAIL start_in_run done_count: got %0d want 1", dones);
        end
        tests++;
        if (bus.out !== 16'h000F) begin
            fails++;
            $display("FAIL start_in_run out: got %h want 000F", bus.out);
        end
    endtask

    task automatic test_mid_reset();
        int   dones;
        vec_t v;
        bus.start = 1'b1;
        bus.in    = 16'h1234;
        bus.cnt   = 4'd15;
        bus.op    = 3'b000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.out} !== {1'b0, 1'b0, 16'h0000}) begin
            fails++;
            $display("FAIL mid_reset immediate: busy=%b done=%b out=%h, want 0/0/0000",
                     bus.busy, bus.done, bus.out);
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        tests++;
        if (dones !== 0) begin
            fails++;
            $display("FAIL mid_reset no_done: got %0d want 0", dones);
        end
        v = '{16'h1234, 4'd4, 3'b000, 16'h2341, 4, 1};
        check_req("after_reset", v);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_ops();
        test_passthru();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
